// File: rtl/cal_expr_parser.sv
// Collects ASCII "digit op digit [terminator]" from the UART and presents a/op/b with a valid/ready handshake.
// Define CAL_EQ_TERM_EN to require a '=' or CR after b (adds the GET_EQ state).
module cal_expr_parser #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [3:0] a,
   output logic [3:0] op,
   output logic [3:0] b,
   output logic       expr_valid,
   input  logic       expr_ready,
   output logic       err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [2:0] GET_A  = 3'd0;
   localparam logic [2:0] GET_OP = 3'd1;
   localparam logic [2:0] GET_B  = 3'd2;
`ifdef CAL_EQ_TERM_EN
   localparam logic [2:0] GET_EQ = 3'd3;
`endif
   localparam logic [2:0] HOLD   = 3'd4;

   logic [2:0]    state, cur, nxt;
   logic [CW-1:0] cnt;
   logic          is_dig, is_op, is_term, is_sp;
   logic          ld_a, ld_op, ld_b, bad, ovr, tmo;
   logic          running, nxt_running;

   assign is_dig  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_op   = (rx_data == 8'h2A) || (rx_data == 8'h2B) ||
                    (rx_data == 8'h2D) || (rx_data == 8'h2F);
   assign is_term = (rx_data == 8'h3D) || (rx_data == 8'h0D);
   assign is_sp   = (rx_data == 8'h20);

   // The inter-byte timer only runs while a partial expression is pending.
   assign running     = (state == GET_OP) || (state == GET_B)
`ifdef CAL_EQ_TERM_EN
                        || (state == GET_EQ)
`endif
                        ;
   assign nxt_running = (nxt == GET_OP) || (nxt == GET_B)
`ifdef CAL_EQ_TERM_EN
                        || (nxt == GET_EQ)
`endif
                        ;

   always_comb begin
      // A handshake edge frees HOLD, so a coincident byte is parsed as in GET_A.
      cur   = (state == HOLD && expr_ready) ? GET_A : state;
      nxt   = cur;
      ld_a  = 1'b0;
      ld_op = 1'b0;
      ld_b  = 1'b0;
      bad   = 1'b0;
      ovr   = 1'b0;
      tmo   = 1'b0;
      if (state == HOLD && !expr_ready) begin
         ovr = rx_valid;
      end else if (rx_valid) begin
         if (!is_sp) begin
            case (cur)
               GET_A: begin
                  if (is_dig) begin
                     ld_a = 1'b1;
                     nxt  = GET_OP;
                  end else if (!is_term) begin
                     bad = 1'b1;
                  end
               end
               GET_OP: begin
                  if (is_op) begin
                     ld_op = 1'b1;
                     nxt   = GET_B;
                  end else begin
                     bad = 1'b1;
                  end
               end
               GET_B: begin
                  if (is_dig) begin
                     ld_b = 1'b1;
`ifdef CAL_EQ_TERM_EN
                     nxt  = GET_EQ;
`else
                     nxt  = HOLD;
`endif
                  end else begin
                     bad = 1'b1;
                  end
               end
`ifdef CAL_EQ_TERM_EN
               GET_EQ: begin
                  if (is_term) nxt = HOLD;
                  else         bad = 1'b1;
               end
`endif
               default: nxt = GET_A;
            endcase
            if (bad) nxt = GET_A;
         end
      end else if (TIMEOUT_CYCLES > 0 && running && int'(cnt) == TIMEOUT_CYCLES - 1) begin
         tmo = 1'b1;
         nxt = GET_A;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= GET_A;
         cnt        <= '0;
         a          <= 4'd0;
         op         <= 4'd0;
         b          <= 4'd0;
         expr_valid <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'b00;
      end else begin
         state      <= nxt;
         expr_valid <= (nxt == HOLD);
         busy       <= (nxt != GET_A) && (nxt != HOLD);
         if (ld_a)  a  <= rx_data[3:0];
         if (ld_op) op <= rx_data[3:0];
         if (ld_b)  b  <= rx_data[3:0];
         err <= bad | tmo | ovr;
         if (bad)      err_code <= 2'b01;
         else if (tmo) err_code <= 2'b10;
         else if (ovr) err_code <= 2'b11;
         // Saturating counter; any received byte restarts the idle window.
         if (!nxt_running || rx_valid)
            cnt <= '0;
         else if (int'(cnt) < TIMEOUT_CYCLES)
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_cal_expr_parser.sv
// Directed, table-driven bench for cal_expr_parser with TIMEOUT_CYCLES = 16.
module tb_cal_expr_parser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [3:0] a, op, b;
   logic       expr_valid;
   logic       expr_ready = 1'b0;
   logic       err;
   logic [1:0] err_code;
   logic       busy;

   int nchk = 0;
   int nerr = 0;

   cal_expr_parser #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .a(a), .op(op), .b(b), .expr_valid(expr_valid), .expr_ready(expr_ready),
      .err(err), .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] c0, c1, c2;
      logic [3:0] ea, eop, eb;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic send(input logic [7:0] d);
      @(negedge clk);
      rx_data  = d;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic term();
`ifdef CAL_EQ_TERM_EN
      chk("no_valid_before_term", expr_valid, 1'b0);
      send(8'h3D);
`endif
   endtask

   task automatic handshake();
      @(negedge clk);
      expr_ready = 1'b1;
      @(posedge clk);
      #1;
      expr_ready = 1'b0;
      chk("hs_valid_low", expr_valid, 1'b0);
      chk("hs_busy_low", busy, 1'b0);
   endtask

   task automatic chk_expr(input logic [3:0] ea, input logic [3:0] eop, input logic [3:0] eb);
      chk("expr_valid", expr_valid, 1'b1);
      chk("expr_a", a, ea);
      chk("expr_op", op, eop);
      chk("expr_b", b, eb);
   endtask

   initial begin
      vt[0] = '{8'h37, 8'h2B, 8'h35, 4'd7, 4'd11, 4'd5};
      vt[1] = '{8'h32, 8'h2A, 8'h38, 4'd2, 4'd10, 4'd8};
      vt[2] = '{8'h39, 8'h2F, 8'h33, 4'd9, 4'd15, 4'd3};
      vt[3] = '{8'h30, 8'h2D, 8'h39, 4'd0, 4'd13, 4'd9};
      vt[4] = '{8'h39, 8'h2A, 8'h39, 4'd9, 4'd10, 4'd9};
      vt[5] = '{8'h31, 8'h2B, 8'h30, 4'd1, 4'd11, 4'd0};

      tick(2);
      chk("rst_valid", expr_valid, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_code", err_code, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_abop", {a, op, b}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Table-driven expressions, consumer holds ready low until checked.
      for (int i = 0; i < 6; i++) begin
         send(vt[i].c0);
         chk("tbl_busy0", busy, 1'b1);
         send(vt[i].c1);
         chk("tbl_busy1", busy, 1'b1);
         send(vt[i].c2);
         term();
         chk_expr(vt[i].ea, vt[i].eop, vt[i].eb);
         chk("tbl_err", err, 1'b0);
         chk("tbl_busy_hold", busy, 1'b0);
         handshake();
      end

      // Ready held high: valid lasts exactly one cycle.
      expr_ready = 1'b1;
      send(8'h37); send(8'h2B); send(8'h35);
      term();
      chk_expr(4'd7, 4'd11, 4'd5);
      tick(1);
      chk("pulse_valid_low", expr_valid, 1'b0);
      expr_ready = 1'b0;

      // Spaces, stalled consumer, overrun while holding.
      send(8'h39); send(8'h20); send(8'h2F); send(8'h20); send(8'h33);
`ifdef CAL_EQ_TERM_EN
      send(8'h0D);
`endif
      for (int k = 0; k < 10; k++) begin
         tick(1);
         chk_expr(4'd9, 4'd15, 4'd3);
      end
      send(8'h35);
      chk("ovr_err", err, 1'b1);
      chk("ovr_code", err_code, 2'b11);
      chk_expr(4'd9, 4'd15, 4'd3);
      tick(1);
      chk("ovr_err_pulse", err, 1'b0);
      chk("ovr_code_hold", err_code, 2'b11);
      handshake();

      // Bad characters in GET_OP, then recovery.
      send(8'h34); send(8'h78);
      chk("bad_err", err, 1'b1);
      chk("bad_code", err_code, 2'b01);
      chk("bad_busy", busy, 1'b0);
      chk("bad_a_kept", a, 4'd4);
      tick(1);
      chk("bad_err_pulse", err, 1'b0);
      send(8'h35); send(8'h35);
      chk("bad_dig_op", err, 1'b1);
      chk("bad_dig_op_busy", busy, 1'b0);
      send(8'h32); send(8'h2A); send(8'h38);
      term();
      chk_expr(4'd2, 4'd10, 4'd8);
      handshake();

      // Timeout fires exactly 16 edges after the last byte.
      send(8'h36);
      for (int k = 1; k <= 16; k++) begin
         tick(1);
         chk("tmo_err", err, (k == 16) ? 1'b1 : 1'b0);
         chk("tmo_busy", busy, (k == 16) ? 1'b0 : 1'b1);
      end
      chk("tmo_code", err_code, 2'b10);
      chk("tmo_a_kept", a, 4'd6);

      // A byte on the boundary edge wins and restarts the window.
      send(8'h36);
      chk("tmo2_code_pre", err_code, 2'b10);
      tick(15);
      send(8'h20);
      chk("tmo_edge_err", err, 1'b0);
      chk("tmo_edge_busy", busy, 1'b1);
      tick(15);
      chk("tmo_restart_quiet", err, 1'b0);
      tick(1);
      chk("tmo_restart_err", err, 1'b1);
      chk("tmo_restart_code", err_code, 2'b10);

      // Handshake edge coinciding with a new digit.
      send(8'h35); send(8'h2B); send(8'h35);
      term();
      chk_expr(4'd5, 4'd11, 4'd5);
      @(negedge clk);
      expr_ready = 1'b1;
      rx_data    = 8'h31;
      rx_valid   = 1'b1;
      @(posedge clk);
      #1;
      expr_ready = 1'b0;
      rx_valid   = 1'b0;
      chk("hsrx_err", err, 1'b0);
      chk("hsrx_valid", expr_valid, 1'b0);
      chk("hsrx_busy", busy, 1'b1);
      chk("hsrx_a", a, 4'd1);
      send(8'h2B); send(8'h32);
      term();
      chk_expr(4'd1, 4'd11, 4'd2);
      handshake();

      // Asynchronous reset in the middle of an expression.
      send(8'h33); send(8'h2D);
      chk("mid_busy", busy, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_abop", {a, op, b}, 12'h000);
      chk("arst_busy", busy, 1'b0);
      chk("arst_code", err_code, 2'b00);
      chk("arst_valid", expr_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'h32); send(8'h2D); send(8'h38);
      term();
      chk_expr(4'd2, 4'd13, 4'd8);
      handshake();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
